// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side controller: output buffer depth and occupancy encoding.
package fifo_rd_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef logic [1:0] buf_cnt_t;

    typedef enum logic [1:0] {
        BUF0 = 2'd0,
        BUF1 = 2'd1,
        BUF2 = 2'd2
    } buf_state_e;

    function automatic buf_cnt_t state_cnt(input buf_state_e s);
        case (s)
            BUF1:    return buf_cnt_t'(1);
            BUF2:    return buf_cnt_t'(2);
            default: return buf_cnt_t'(0);
        endcase
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus the valid/ready output stream of the read controller.
interface fifo_rd_ctrl_if #(
    parameter int unsigned FIFO_WIDTH = 16
) ();

    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry output buffer; entry 0 is always the head so the output needs no mux.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output buf_state_e       o_state
);

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic             w_push;
    logic             w_pop;
    logic             w_wr_hi;

    always_comb begin
        w_push      = i_push && !i_flush;
        w_pop       = i_pop && !i_flush;
        // After a simultaneous pop the surviving word has shifted down, so the tail moves too.
        w_wr_hi     = (r_state == BUF2) || ((r_state == BUF1) && !w_pop);
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = BUF0;
        end else if (w_push && !w_pop) begin
            case (r_state)
                BUF0:    w_state_nxt = BUF1;
                BUF1:    w_state_nxt = BUF2;
                default: w_state_nxt = r_state;
            endcase
        end else if (!w_push && w_pop) begin
            case (r_state)
                BUF2:    w_state_nxt = BUF1;
                BUF1:    w_state_nxt = BUF0;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_mem[0] <= r_mem[1];
            end
            if (w_push) begin
                if (w_wr_hi) begin
                    r_mem[1] <= i_din;
                end else begin
                    r_mem[0] <= i_din;
                end
            end
        end
    end

    assign o_head  = r_mem[0];
    assign o_state = r_state;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: issues FIFO reads only when the buffer can absorb the returning word.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_rd_ctrl_if.master        bus,
    input  logic                  flush,
    output logic                  err_underflow,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    buf_state_e            w_state;
    logic [FIFO_WIDTH-1:0] w_head;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_rd_en;
    buf_cnt_t              w_occ;
    logic                  r_inflight;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_word_cnt;

    fifo_rd_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_din   (bus.fifo_data_out),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_head  (w_head),
        .o_state (w_state)
    );

    assign w_valid = (w_state != BUF0);
    assign w_pop   = w_valid && bus.m_ready;
    // Buffered plus in-flight words must never exceed the buffer depth.
    assign w_occ   = state_cnt(w_state) + buf_cnt_t'(r_inflight);
    assign w_rd_en = !rst && !flush && !bus.fifo_empty
                     && ((w_occ < buf_cnt_t'(BUF_DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (bus.fifo_underflow) begin
                r_err <= 1'b1;
            end
            if (w_pop && !flush) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_head;
    assign err_underflow  = r_err;
    assign word_cnt       = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl driving a behavioural FIFO with one-cycle read latency.
module tb_fifo_rd_ctrl;
    import fifo_rd_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          force_uf;
    logic          r_model_uf;
    logic          err_underflow;
    logic [CW-1:0] word_cnt;
    logic [W-1:0]  mem [256];
    logic [W-1:0]  r_dout;
    int            wr_ptr;
    int            rd_ptr = 0;
    int            n_checks;
    int            n_err;
    int            n_deliv;
    int            cnt_before;
    logic          stall_prev;
    logic [W-1:0]  prev_data;
    logic [12:0]   bp_exp;
    logic [W-1:0]  exp_q [$];

    fifo_rd_ctrl_if #(.FIFO_WIDTH(W)) bus ();

    fifo_rd_ctrl #(
        .FIFO_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .flush         (flush),
        .err_underflow (err_underflow),
        .word_cnt      (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.fifo_empty     = (rd_ptr == wr_ptr);
    assign bus.fifo_data_out  = r_dout;
    assign bus.fifo_underflow = r_model_uf | force_uf;

    always @(posedge clk) begin
        r_model_uf <= bus.fifo_rd_en && (rd_ptr == wr_ptr);
        if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            r_dout <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr++;
        exp_q.push_back(v);
    endtask

    task automatic sb_step();
        logic [W-1:0] e;
        int occ;
        occ = (dut.w_state == BUF2) ? 2 : ((dut.w_state == BUF1) ? 1 : 0);
        occ += int'(dut.r_inflight);
        chk("occupancy_le_2", 32'(occ <= 2), 32'd1);
        chk("word_cnt", 32'(word_cnt), 32'(n_deliv % (1 << CW)));
        if (stall_prev) chk("hold_m_data", 32'(bus.m_data), 32'(prev_data));
        if (bus.m_valid && bus.m_ready && !flush) begin
            chk("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_data", 32'(bus.m_data), 32'(e));
            end
            n_deliv++;
        end
        stall_prev = bus.m_valid && !bus.m_ready && !flush && !rst;
        prev_data  = bus.m_data;
    endtask

    task automatic sample();
        @(negedge clk);
        sb_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            sample();
            advance();
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        force_uf    = 1'b0;
        bus.m_ready = 1'b0;
        wr_ptr      = 0;
        n_checks    = 0;
        n_err       = 0;
        n_deliv     = 0;
        stall_prev  = 1'b0;
        prev_data   = '0;
        bp_exp      = 13'b0111110000111;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        advance();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            sample();
            chk("idle_rd_en", 32'(bus.fifo_rd_en), 32'd0);
            chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
            advance();
        end

        // Single word: read in t, data in t+1, delivered in t+2.
        bus.m_ready = 1'b1;
        push_word(16'hA5A5);
        sample();
        chk("single_rd_en_t", 32'(bus.fifo_rd_en), 32'd1);
        advance();
        sample();
        chk("single_rd_en_t1", 32'(bus.fifo_rd_en), 32'd0);
        chk("single_valid_t1", 32'(bus.m_valid), 32'd0);
        advance();
        sample();
        chk("single_valid_t2", 32'(bus.m_valid), 32'd1);
        chk("single_data_t2", 32'(bus.m_data), 32'hA5A5);
        advance();
        sample();
        chk("single_valid_t3", 32'(bus.m_valid), 32'd0);
        chk("single_cnt", 32'(word_cnt), 32'd1);
        advance();

        for (int i = 1; i <= 8; i++) push_word(W'(i));
        for (int c = 0; c <= 10; c++) begin
            sample();
            chk("stream_rd_en", 32'(bus.fifo_rd_en), 32'(c < 8));
            chk("stream_valid", 32'(bus.m_valid), 32'((c >= 2) && (c < 10)));
            advance();
        end
        chk("stream_cnt", 32'(word_cnt), 32'd9);

        // Back-pressure: ready low in cycles 3..6; word_cnt wraps past 15 here.
        for (int i = 0; i < 8; i++) push_word(16'h0010 + W'(i));
        for (int c = 0; c <= 12; c++) begin
            bus.m_ready = !((c >= 3) && (c <= 6));
            sample();
            chk("bp_rd_en", 32'(bus.fifo_rd_en), 32'(bp_exp[c]));
            advance();
        end
        drain("bp");
        chk("bp_no_underflow", 32'(err_underflow), 32'd0);

        // Flush with one word buffered and one in flight: both are lost.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'h0020 + W'(i));
        sample();
        chk("fl_rd_en_c0", 32'(bus.fifo_rd_en), 32'd1);
        advance();
        sample();
        chk("fl_rd_en_c1", 32'(bus.fifo_rd_en), 32'd1);
        advance();
        flush       = 1'b1;
        bus.m_ready = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        cnt_before = n_deliv;
        sample();
        chk("flush_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        advance();
        flush = 1'b0;
        sample();
        chk("flush_valid_after", 32'(bus.m_valid), 32'd0);
        chk("flush_rd_resume", 32'(bus.fifo_rd_en), 32'd1);
        chk("flush_cnt", 32'(word_cnt), 32'(cnt_before % (1 << CW)));
        advance();
        drain("flush");

        // Asynchronous reset mid-cycle with data buffered and in flight.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(16'h0030 + W'(i));
        sample();
        advance();
        sample();
        advance();
        sample();
        chk("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.m_valid), 32'd0);
        chk("arst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("arst_cnt", 32'(word_cnt), 32'd0);
        chk("arst_m_data", 32'(bus.m_data), 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        n_deliv    = 0;
        stall_prev = 1'b0;
        advance();
        sample();
        advance();
        rst         = 1'b0;
        bus.m_ready = 1'b1;
        sample();
        chk("post_rst_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        advance();
        drain("rst");

        chk("uf_clear", 32'(err_underflow), 32'd0);
        force_uf = 1'b1;
        sample();
        chk("uf_same_cycle", 32'(err_underflow), 32'd0);
        advance();
        force_uf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("uf_sticky", 32'(err_underflow), 32'd1);
            advance();
        end
        #1 rst = 1'b1;
        #1;
        chk("uf_rst_clear", 32'(err_underflow), 32'd0);
        n_deliv    = 0;
        stall_prev = 1'b0;
        advance();
        rst = 1'b0;
        sample();
        chk("uf_after_rst", 32'(err_underflow), 32'd0);
        advance();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
